hy_cnt_arb: RTL and testbench

Round-robin scheduler that shares one hyCnt countdown timer among C_NREQ requesters.
- Each requester asks for a timed interval of a given length.
- The block grants the timer to one requester at a time, loads the count, waits for the timer interrupt, then returns a one-cycle done pulse to the owner.
- Sits between the per-channel control logic and the single hyCnt instance.

---
 rtl/hy_cnt_arb_pkg.sv | 17 +
 rtl/hy_cnt_arb_if.sv | 35 +++
 rtl/hy_rr_arb.sv | 42 ++++
 rtl/hy_cnt_arb.sv | 138 +++++++++++++
 tb/tb_hy_cnt_arb.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hy_cnt_arb_pkg.sv
// Shared definitions for the hyCnt timer arbiter: FSM encodings and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hy_cnt_arb_pkg;

   localparam int C_WIDTH_DEF = 8;   // interval / hyCnt width
   localparam int C_NREQ_DEF  = 4;   // number of requesters
   localparam int C_IDX_W_DEF = 2;   // owner index width, >= clog2(C_NREQ)

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/hy_cnt_arb_if.sv
// Bundle between the requesters, the arbiter and the shared hyCnt timer.
// Latency: n/a (wires only).
// Backpressure: req is a level held by the requester until done or until it aborts.
// Ports: req/len from requesters; gnt/done/busy/gnt_idx back to them;
//        cnt_in/cnt_ld to hyCnt, cnt_int from hyCnt.
//        master = arbiter side, slave = requesters + counter side.
interface hy_cnt_arb_if
   import hy_cnt_arb_pkg::*;
#(
   parameter int C_WIDTH = C_WIDTH_DEF,
   parameter int C_NREQ  = C_NREQ_DEF,
   parameter int C_IDX_W = C_IDX_W_DEF
);

   logic [C_NREQ-1:0]         req;
   logic [C_NREQ*C_WIDTH-1:0] len;
   logic [C_NREQ-1:0]         gnt;
   logic [C_NREQ-1:0]         done;
   logic                      busy;
   logic [C_IDX_W-1:0]        gnt_idx;
   logic [C_WIDTH-1:0]        cnt_in;
   logic                      cnt_ld;
   logic                      cnt_int;

   modport master (
      input  req, len, cnt_int,
      output gnt, done, busy, gnt_idx, cnt_in, cnt_ld
   );

   modport slave (
      output req, len, cnt_int,
      input  gnt, done, busy, gnt_idx, cnt_in, cnt_ld
   );

endinterface

// File: rtl/hy_rr_arb.sv
// Combinational round-robin picker; optional fixed top priority for requester 0.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when to act on the winner.
// Ports: req (request vector), ptr (first index searched), prio (requester 0 wins
//        outright, others rotate) -> win_oh (one-hot winner), win_idx, win_vld.
module hy_rr_arb #(
   parameter int C_NREQ  = 4,
   parameter int C_IDX_W = 2
) (
   input  logic [C_NREQ-1:0]  req,
   input  logic [C_IDX_W-1:0] ptr,
   input  logic               prio,
   output logic [C_NREQ-1:0]  win_oh,
   output logic [C_IDX_W-1:0] win_idx,
   output logic               win_vld
);

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      win_vld = 1'b0;
      if (prio && req[0]) begin
         win_oh[0] = 1'b1;
         win_vld   = 1'b1;
      end else begin
         // Walk candidates ptr, ptr+1, ... (mod C_NREQ); the inner loop keeps
         // every select index a loop constant. In prio mode requester 0 is
         // already handled above, so it is skipped in the rotation.
         for (int k = 0; k < C_NREQ; k++) begin
            for (int i = 0; i < C_NREQ; i++) begin
               if (!win_vld && req[i] && !(prio && i == 0) &&
                   i == (int'(ptr) + k) % C_NREQ) begin
                  win_oh[i] = 1'b1;
                  win_idx   = C_IDX_W'(i);
                  win_vld   = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/hy_cnt_arb.sv
// Round-robin scheduler sharing one hyCnt countdown timer among C_NREQ requesters.
// Latency: gnt+cnt_ld one cycle after the IDLE decision; done the cycle after cnt_int is taken.
// Backpressure: non-owners stay pending while busy; owner dropping req in LOAD/RUN aborts.
// Ports: clk, rst_n (async, active low); bus (hy_cnt_arb_if.master) carries
//        req/len in, gnt/done/busy/gnt_idx out, cnt_in/cnt_ld to hyCnt, cnt_int back.
// Build option: define HY_CNT_ARB_PRIO_EN to give requester 0 fixed top priority in IDLE.
module hy_cnt_arb
   import hy_cnt_arb_pkg::*;
#(
   parameter int C_WIDTH = C_WIDTH_DEF,
   parameter int C_NREQ  = C_NREQ_DEF,
   parameter int C_IDX_W = C_IDX_W_DEF
) (
   input logic          clk,
   input logic          rst_n,
   hy_cnt_arb_if.master bus
);

`ifdef HY_CNT_ARB_PRIO_EN
   localparam logic C_PRIO = 1'b1;
`else
   localparam logic C_PRIO = 1'b0;
`endif

   state_t             state_q, state_d;
   logic [C_NREQ-1:0]  gnt_q,   gnt_d;
   logic [C_IDX_W-1:0] idx_q,   idx_d;
   logic [C_IDX_W-1:0] ptr_q,   ptr_d;
   logic [C_WIDTH-1:0] cnt_q,   cnt_d;
   logic               zero_q,  zero_d;

   logic [C_NREQ-1:0]  win_oh;
   logic [C_IDX_W-1:0] win_idx;
   logic               win_vld;
   logic [C_WIDTH-1:0] win_len;
   logic [C_IDX_W-1:0] nxt_ptr;
   logic               owner_req;

   hy_rr_arb #(
      .C_NREQ  (C_NREQ),
      .C_IDX_W (C_IDX_W)
   ) u_rr (
      .req     (bus.req),
      .ptr     (ptr_q),
      .prio    (C_PRIO),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .win_vld (win_vld)
   );

   always_comb begin
      win_len = '0;
      for (int i = 0; i < C_NREQ; i++) begin
         if (win_oh[i]) win_len = bus.len[i*C_WIDTH +: C_WIDTH];
      end
   end

   // gnt_q is one-hot while busy, so masking avoids a variable bit-select.
   assign owner_req = |(bus.req & gnt_q);
   // The just-served owner drops to lowest priority.
   assign nxt_ptr   = (idx_q == C_IDX_W'(C_NREQ - 1)) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               gnt_d   = win_oh;
               idx_d   = win_idx;
               cnt_d   = win_len;
               zero_d  = (win_len == '0);
               state_d = LOAD;
            end
         end
         LOAD: begin
            // A zero-length interval still occupies this slot with the strobe
            // suppressed, so done lands two cycles after the decision and
            // the counter is never touched.
            if (!owner_req) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = nxt_ptr;
            end else if (zero_q) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Abort is checked first so it wins over a coincident cnt_int.
            if (!owner_req) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = nxt_ptr;
            end else if (bus.cnt_int) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = nxt_ptr;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.done    = (state_q == DONE) ? gnt_q : '0;
   assign bus.busy    = (state_q != IDLE);
   assign bus.gnt_idx = idx_q;
   assign bus.cnt_in  = cnt_q;
   assign bus.cnt_ld  = (state_q == LOAD) && !zero_q;

endmodule

// File: tb/tb_hy_cnt_arb.sv
module tb_hy_cnt_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       model_int;
   logic       inj_int;
   logic [7:0] mcnt;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         rr_ptr;
   logic [3:0] exp_done[$];
   logic [7:0] exp_ld[$];

   hy_cnt_arb_if bus ();

   hy_cnt_arb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // hyCnt model: loads on cnt_ld, counts down, pulses when it reaches zero.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                mcnt <= 8'd0;
      else if (bus.cnt_ld)       mcnt <= bus.cnt_in;
      else if (mcnt != 8'd0)     mcnt <= mcnt - 8'd1;
   end
   assign model_int   = (mcnt == 8'd1);
   assign bus.cnt_int = model_int | inj_int;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      return 4'(1 << i);
   endfunction

   task automatic wait_done(input string tag, output int cyc, output logic [3:0] seen);
      cyc  = 0;
      seen = 4'd0;
      while (cyc < 100 && seen == 4'd0) begin
         @(negedge clk);
         cyc++;
         seen = bus.done;
      end
      chk({tag, "_done_seen"}, 32'(seen != 4'd0), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_gnt"},  32'(bus.gnt),  32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
   endtask

   // Scoreboard side: every done and every load is matched against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
         if (bus.done != 4'd0) begin
            if (exp_done.size() > 0) chk("done_vec", 32'(bus.done), 32'(exp_done.pop_front()));
            else                     chk("done_unexpected", 32'(bus.done), 32'd0);
         end
         if (bus.cnt_ld) begin
            if (exp_ld.size() > 0)   chk("ld_val", 32'(bus.cnt_in), 32'(exp_ld.pop_front()));
            else                     chk("ld_unexpected", 32'(bus.cnt_ld), 32'd0);
         end
      end
   end

   initial begin
      int         cyc;
      logic [3:0] seen;
      logic       quiet;
      int         first, second;

      rst_n   = 1'b0;
      inj_int = 1'b0;
      bus.req = '0;
      bus.len = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt",    32'(bus.gnt),     32'd0);
      chk("rst_done",   32'(bus.done),    32'd0);
      chk("rst_busy",   32'(bus.busy),    32'd0);
      chk("rst_idx",    32'(bus.gnt_idx), 32'd0);
      chk("rst_cnt_in", 32'(bus.cnt_in),  32'd0);
      chk("rst_cnt_ld", 32'(bus.cnt_ld),  32'd0);
      rst_n  = 1'b1;
      rr_ptr = 0;

      // Single requester, len 5.
      @(negedge clk);
      bus.len = {8'd0, 8'd0, 8'd0, 8'h05};
      bus.req = 4'b0001;
      exp_ld.push_back(8'h05);
      exp_done.push_back(4'b0001);
      @(negedge clk);
      chk("t1_gnt",    32'(bus.gnt),     32'h1);
      chk("t1_cnt_ld", 32'(bus.cnt_ld),  32'd1);
      chk("t1_cnt_in", 32'(bus.cnt_in),  32'h05);
      chk("t1_idx",    32'(bus.gnt_idx), 32'd0);
      chk("t1_busy",   32'(bus.busy),    32'd1);
      wait_done("t1", cyc, seen);
      chk("t1_latency", 32'(cyc), 32'd6);
      chk("t1_busy_at_done", 32'(bus.busy), 32'd1);
      bus.req = '0;
      @(negedge clk);
      chk_idle("t1_after");
      rr_ptr = 1;

      // All four requesting, len 3: five intervals in rotation.
      bus.len = {4{8'd3}};
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_ld.push_back(8'd3);
         exp_done.push_back(oh((rr_ptr + k) % 4));
      end
      for (int k = 0; k < 5; k++) begin
         wait_done("t2", cyc, seen);
         if (k == 4) bus.req = '0;
      end
      @(negedge clk);
      chk_idle("t2_after");
      rr_ptr = (rr_ptr + 5) % 4;

      // Zero length on requester 2: done with no load strobe.
      bus.len = '0;
      bus.req = 4'b0100;
      exp_done.push_back(4'b0100);
      @(negedge clk);
      chk("t3_gnt",    32'(bus.gnt),    32'h4);
      chk("t3_cnt_ld", 32'(bus.cnt_ld), 32'd0);
      wait_done("t3", cyc, seen);
      chk("t3_latency", 32'(cyc), 32'd1);
      bus.req = '0;
      @(negedge clk);
      chk_idle("t3_after");
      rr_ptr = 3;

      // Abort: requester 1 drops req 10 cycles into RUN.
      bus.len = {8'd0, 8'd0, 8'h20, 8'd0};
      bus.req = 4'b0010;
      exp_ld.push_back(8'h20);
      @(negedge clk);
      chk("t4_gnt", 32'(bus.gnt), 32'h2);
      repeat (10) @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      chk_idle("t4_abort");
      quiet = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (bus.busy || bus.gnt != 4'd0 || bus.done != 4'd0) quiet = 1'b0;
      end
      chk("t4_late_int_quiet", 32'(quiet), 32'd1);
      inj_int = 1'b1;
      @(negedge clk);
      inj_int = 1'b0;
      @(negedge clk);
      chk_idle("t4_inject");
      rr_ptr = 2;

      // After abort the pointer sits at 2: req 0011 grants 0 then 1.
      bus.len = {8'd0, 8'd0, 8'd2, 8'd2};
      bus.req = 4'b0011;
      exp_ld.push_back(8'd2);
      exp_ld.push_back(8'd2);
      exp_done.push_back(4'b0001);
      exp_done.push_back(4'b0010);
      @(negedge clk);
      chk("t4b_gnt", 32'(bus.gnt), 32'h1);
      wait_done("t4b", cyc, seen);
      bus.req = bus.req & ~seen;
      wait_done("t4b", cyc, seen);
      bus.req = '0;
      @(negedge clk);
      chk_idle("t4b_after");
      rr_ptr = 2;

      // Abort and cnt_int in the same RUN cycle: abort wins.
      bus.len = {8'd0, 8'd4, 8'd0, 8'd0};
      bus.req = 4'b0100;
      exp_ld.push_back(8'd4);
      @(negedge clk);
      chk("t5_gnt", 32'(bus.gnt), 32'h4);
      cyc = 0;
      while (cyc < 30 && !bus.cnt_int) begin
         @(negedge clk);
         cyc++;
      end
      chk("t5_int_seen", 32'(bus.cnt_int), 32'd1);
      bus.req = '0;
      @(negedge clk);
      chk_idle("t5_after");
      rr_ptr = 3;

      // Asynchronous reset in the middle of RUN.
      bus.len = {8'd10, 8'd0, 8'd0, 8'd0};
      bus.req = 4'b1000;
      exp_ld.push_back(8'd10);
      @(negedge clk);
      chk("t6_gnt", 32'(bus.gnt),     32'h8);
      chk("t6_idx", 32'(bus.gnt_idx), 32'd3);
      repeat (2) @(negedge clk);
      chk("t6_busy_run", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_gnt",    32'(bus.gnt),     32'd0);
      chk("t6_rst_busy",   32'(bus.busy),    32'd0);
      chk("t6_rst_idx",    32'(bus.gnt_idx), 32'd0);
      chk("t6_rst_cnt_in", 32'(bus.cnt_in),  32'd0);
      chk("t6_rst_cnt_ld", 32'(bus.cnt_ld),  32'd0);
      chk("t6_rst_done",   32'(bus.done),    32'd0);
      bus.req = '0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      rr_ptr = 0;

      bus.len = {8'd0, 8'd0, 8'd0, 8'd3};
      bus.req = 4'b0001;
      exp_ld.push_back(8'd3);
      exp_done.push_back(4'b0001);
      @(negedge clk);
      chk("t6b_gnt", 32'(bus.gnt), 32'h1);
      wait_done("t6b", cyc, seen);
      bus.req = '0;
      @(negedge clk);
      chk_idle("t6b_after");
      rr_ptr = 1;

      // req 1001 with the pointer at 1: priority mode serves 0 first,
      // plain round-robin reaches 3 first.
`ifdef HY_CNT_ARB_PRIO_EN
      first  = 0;
      second = 3;
`else
      first  = 3;
      second = 0;
`endif
      bus.len = {8'd2, 8'd0, 8'd0, 8'd2};
      bus.req = 4'b1001;
      exp_ld.push_back(8'd2);
      exp_ld.push_back(8'd2);
      exp_done.push_back(oh(first));
      exp_done.push_back(oh(second));
      @(negedge clk);
      chk("t7_gnt", 32'(bus.gnt),     32'(oh(first)));
      chk("t7_idx", 32'(bus.gnt_idx), 32'(first));
      wait_done("t7", cyc, seen);
      bus.req = bus.req & ~seen;
      wait_done("t7", cyc, seen);
      bus.req = '0;
      @(negedge clk);
      chk_idle("t7_after");

      chk("sb_done_left", 32'(exp_done.size()), 32'd0);
      chk("sb_ld_left",   32'(exp_ld.size()),   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
